piece_controller: RTL and testbench



---
 rtl/tetris_pkg.sv | 53 +++++
 rtl/piece_controller_key_repeat.sv | 85 ++++++++
 rtl/piece_controller.sv | 175 +++++++++++++++++
 tb/tb_piece_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared constants, enums and helpers for the falling-piece controller.
//   Playfield geometry (10x20 cells of 24 px starting at X=200), keycodes,
//   the piece FSM state enum, the key direction enum, the occupancy grid
//   type, and two small helpers:
//     cell_times24 : n*24 built from two shifts and one add
//     cell_is_occ  : occupancy lookup that returns 0 outside the grid
package tetris_pkg;

   localparam int GRID_X0   = 200;
   localparam int CELL      = 24;
   localparam int HALF      = 12;
   localparam int COLS      = 10;
   localparam int ROWS      = 20;
   localparam int SPAWN_COL = 4;

   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_S = 8'h16;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      LOCK  = 2'd1,
      SPAWN = 2'd2,
      OVER  = 2'd3
   } piece_state_t;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_t;

   typedef logic [ROWS-1:0][COLS-1:0] occ_grid_t;

   function automatic logic [9:0] cell_times24(input logic [4:0] n);
      logic [9:0] n_w;
      n_w = {5'd0, n};
      return (n_w << 4) + (n_w << 3);
   endfunction

   function automatic logic cell_is_occ(input occ_grid_t grid,
                                        input logic [4:0] r,
                                        input logic [3:0] c);
      logic hit;
      hit = 1'b0;
      if (r < 5'(ROWS) && c < 4'(COLS)) begin
         hit = grid[r][c];
      end
      return hit;
   endfunction

endpackage

// File: rtl/piece_controller_key_repeat.sv
// key_repeat
//   Turns the held keycode into one-tick move strobes.  A new press (or a
//   change of direction) fires on the next enabled tick; while the key stays
//   held it fires again every REPEAT_FRAMES enabled ticks.  Releasing the key
//   clears the repeat counter at once, even while ticks are disabled.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   tick_en       : frame tick qualified by the controller (PLAY only)
//   keycode[7:0]  : current HID keycode
//   move_left     : strobe, high with tick_en when a left move is due
//   move_right    : strobe, high with tick_en when a right move is due
module key_repeat
   import tetris_pkg::*;
#(
   parameter int REPEAT_FRAMES = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick_en,
   input  logic [7:0] keycode,
   output logic       move_left,
   output logic       move_right
);

   localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_FRAMES - 1);

   dir_t          dir;
   dir_t          dir_prev_q, dir_prev_d;
   logic          pending_q, pending_d;
   logic [RW-1:0] rpt_q, rpt_d;
   logic          fire;

   always_comb begin
      dir = DIR_NONE;
      if (keycode == KEY_A) begin
         dir = DIR_LEFT;
      end else if (keycode == KEY_D) begin
         dir = DIR_RIGHT;
      end
   end

   always_comb begin
      dir_prev_d = dir;
      pending_d  = pending_q;
      rpt_d      = rpt_q;
      fire       = 1'b0;
      // A press can land between ticks; remember it until a tick consumes it.
      if (dir != DIR_NONE && dir != dir_prev_q) begin
         pending_d = 1'b1;
      end
      if (dir == DIR_NONE) begin
         pending_d = 1'b0;
         rpt_d     = '0;
      end
      if (tick_en && dir != DIR_NONE) begin
         if (pending_d) begin
            fire      = 1'b1;
            pending_d = 1'b0;
            rpt_d     = '0;
         end else if (rpt_q == RPT_LAST) begin
            fire  = 1'b1;
            rpt_d = '0;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         dir_prev_q <= DIR_NONE;
         pending_q  <= 1'b0;
         rpt_q      <= '0;
      end else begin
         dir_prev_q <= dir_prev_d;
         pending_q  <= pending_d;
         rpt_q      <= rpt_d;
      end
   end

   assign move_left  = fire && (dir == DIR_LEFT);
   assign move_right = fire && (dir == DIR_RIGHT);

endmodule

// File: rtl/piece_controller.sv
// piece_controller
//   Sequences the single falling cell on the 10x20 playfield: keyboard
//   moves and timed gravity once per frame, collision against walls, floor
//   and locked cells, occupancy recording, respawn and game over.
//   Optional build macro SOFT_DROP_EN: while keycode 0x16 is held, gravity
//   is due on every tick in PLAY (the gravity counter keeps advancing).
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   frame_tick          : one-cycle pulse per video frame
//   keycode[7:0]        : current HID keycode (A=left, D=right, S=soft drop)
//   BallX/BallY[9:0]    : pixel centre of the piece
//   Ball_size[9:0]      : constant half-cell size (12)
//   lock_valid          : one-cycle pulse when the piece locks
//   lock_col/lock_row   : locked cell, valid with lock_valid
//   game_over           : sticky until Reset
//   occ_col/occ_row     : occupancy read address
//   occ_data            : occupancy bit, 0 for out-of-range addresses
//
// state | meaning
// PLAY  | piece falling; moves and gravity applied on frame_tick
// LOCK  | one cycle; cell written to occupancy, lock_valid pulsed
// SPAWN | one cycle; respawn at (row 0, col 4) or declare game over
// OVER  | frozen until Reset
module piece_controller
   import tetris_pkg::*;
#(
   parameter int DROP_FRAMES   = 30,
   parameter int REPEAT_FRAMES = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] Ball_size,
   output logic       lock_valid,
   output logic [3:0] lock_col,
   output logic [4:0] lock_row,
   output logic       game_over,
   input  logic [3:0] occ_col,
   input  logic [4:0] occ_row,
   output logic       occ_data
);

   localparam int GW = $clog2(DROP_FRAMES);
   localparam logic [GW-1:0] GRAV_LAST = GW'(DROP_FRAMES - 1);
   localparam logic [3:0] COL_MAX  = 4'(COLS - 1);
   localparam logic [4:0] ROW_MAX  = 5'(ROWS - 1);
   localparam logic [3:0] COL_SPWN = 4'(SPAWN_COL);

   piece_state_t  state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [4:0]    row_q, row_d;
   logic [GW-1:0] grav_q, grav_d;
   occ_grid_t     occ_q, occ_d;
   logic [3:0]    lock_col_q, lock_col_d;
   logic [4:0]    lock_row_q, lock_row_d;

   logic          move_left, move_right;
   logic          soft_drop;
   logic          grav_wrap;
   logic          drop_due;
   logic [3:0]    col_mv;

   key_repeat #(
      .REPEAT_FRAMES (REPEAT_FRAMES)
   ) u_key_repeat (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick_en    (frame_tick && (state_q == PLAY)),
      .keycode    (keycode),
      .move_left  (move_left),
      .move_right (move_right)
   );

`ifdef SOFT_DROP_EN
   assign soft_drop = (keycode == KEY_S);
`else
   assign soft_drop = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= PLAY;
         col_q      <= COL_SPWN;
         row_q      <= '0;
         grav_q     <= '0;
         occ_q      <= '0;
         lock_col_q <= '0;
         lock_row_q <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         grav_q     <= grav_d;
         occ_q      <= occ_d;
         lock_col_q <= lock_col_d;
         lock_row_q <= lock_row_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      grav_d     = grav_q;
      occ_d      = occ_q;
      lock_col_d = lock_col_q;
      lock_row_d = lock_row_q;
      col_mv     = col_q;
      grav_wrap  = 1'b0;
      drop_due   = 1'b0;
      case (state_q)
         PLAY: begin
            if (frame_tick) begin
               // Horizontal first; gravity then tests the moved column.
               if (move_left && col_q != 4'd0 &&
                   !cell_is_occ(occ_q, row_q, col_q - 4'd1)) begin
                  col_mv = col_q - 4'd1;
               end else if (move_right && col_q != COL_MAX &&
                            !cell_is_occ(occ_q, row_q, col_q + 4'd1)) begin
                  col_mv = col_q + 4'd1;
               end
               col_d     = col_mv;
               grav_wrap = (grav_q == GRAV_LAST);
               grav_d    = grav_wrap ? '0 : grav_q + 1'b1;
               drop_due  = grav_wrap || soft_drop;
               if (drop_due) begin
                  if (row_q == ROW_MAX ||
                      cell_is_occ(occ_q, row_q + 5'd1, col_mv)) begin
                     state_d    = LOCK;
                     lock_col_d = col_mv;
                     lock_row_d = row_q;
                  end else begin
                     row_d = row_q + 5'd1;
                  end
               end
            end
         end
         LOCK: begin
            occ_d[row_q][col_q] = 1'b1;
            state_d             = SPAWN;
         end
         SPAWN: begin
            if (occ_q[0][SPAWN_COL]) begin
               state_d = OVER;
            end else begin
               col_d   = COL_SPWN;
               row_d   = '0;
               grav_d  = '0;
               state_d = PLAY;
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = PLAY;
         end
      endcase
   end

   always_comb begin
      BallX      = 10'(GRID_X0 + HALF) + cell_times24({1'b0, col_q});
      BallY      = 10'(HALF) + cell_times24(row_q);
      Ball_size  = 10'(HALF);
      lock_valid = (state_q == LOCK);
      lock_col   = lock_col_q;
      lock_row   = lock_row_q;
      game_over  = (state_q == OVER);
      occ_data   = cell_is_occ(occ_q, occ_row, occ_col);
   end

endmodule

// File: tb/tb_piece_controller.sv
module tb_piece_controller;

   localparam int S_BX  = 0;
   localparam int S_BY  = 1;
   localparam int S_SZ  = 2;
   localparam int S_GO  = 3;
   localparam int S_LV  = 4;
   localparam int S_LC  = 5;
   localparam int S_LR  = 6;
   localparam int S_OCC = 7;

   typedef struct {
      string tag;
      int    sel;
      int    exp;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [9:0] BallX, BallY, Ball_size;
   logic       lock_valid, game_over, occ_data;
   logic [3:0] lock_col;
   logic [4:0] lock_row;
   logic [3:0] occ_col = 4'd0;
   logic [4:0] occ_row = 5'd0;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   int   lock_q[$];
   int   n_lock_pushed = 0;
   int   n_lock_seen = 0;
   logic lv_prev = 1'b0;

   piece_controller dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .BallX      (BallX),
      .BallY      (BallY),
      .Ball_size  (Ball_size),
      .lock_valid (lock_valid),
      .lock_col   (lock_col),
      .lock_row   (lock_row),
      .game_over  (game_over),
      .occ_col    (occ_col),
      .occ_row    (occ_row),
      .occ_data   (occ_data)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   function automatic int observe(input int sel);
      case (sel)
         S_BX:    return int'(BallX);
         S_BY:    return int'(BallY);
         S_SZ:    return int'(Ball_size);
         S_GO:    return int'(game_over);
         S_LV:    return int'(lock_valid);
         S_LC:    return int'(lock_col);
         S_LR:    return int'(lock_row);
         default: return int'(occ_data);
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input int e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      exp_q.push_back(x);
   endtask

   task automatic drain();
      exp_t x;
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk(x.tag, observe(x.sel), x.exp);
      end
   endtask

   task automatic expect_occ(input string tag, input int r, input int c, input int e);
      occ_row = 5'(r);
      occ_col = 4'(c);
      #1;
      expect_val(tag, S_OCC, e);
      drain();
   endtask

   task automatic expect_lock(input int c, input int r);
      lock_q.push_back(c * 32 + r);
      n_lock_pushed++;
   endtask

   // One frame_tick captured on a posedge, then `idle` further cycles.
   task automatic tick(input int idle);
      @(negedge Clk);
      frame_tick = 1'b1;
      @(posedge Clk);
      #1 frame_tick = 1'b0;
      repeat (idle) @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(3);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      int ones;
      expect_val({pfx, "_bx"}, S_BX, 308);
      expect_val({pfx, "_by"}, S_BY, 12);
      expect_val({pfx, "_size"}, S_SZ, 12);
      expect_val({pfx, "_go"}, S_GO, 0);
      expect_val({pfx, "_lv"}, S_LV, 0);
      expect_val({pfx, "_lcol"}, S_LC, 0);
      expect_val({pfx, "_lrow"}, S_LR, 0);
      drain();
      ones = 0;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 16; c++) begin
            occ_row = 5'(r);
            occ_col = 4'(c);
            #1;
            if (occ_data) ones++;
         end
      end
      chk({pfx, "_occ_ones"}, ones, 0);
   endtask

   // Scoreboard side for lock pulses.
   always @(negedge Clk) begin
      if (lock_valid) begin
         n_lock_seen++;
         if (lock_q.size() == 0) begin
            chk("lock_unexpected", 1, 0);
         end else begin
            int e;
            e = lock_q.pop_front();
            chk("lock_col", int'(lock_col), e / 32);
            chk("lock_row", int'(lock_row), e % 32);
         end
         if (lv_prev) chk("lock_pulse_width", 2, 1);
      end
      lv_prev <= lock_valid;
   end

   initial begin
      // Reset
      do_reset();
      check_reset_state("reset");

      // Gravity
      ticks(29);
      expect_val("grav_29", S_BY, 12);
      drain();
      ticks(1);
      expect_val("grav_30", S_BY, 36);
      drain();

      // Hold D from spawn
      do_reset();
      keycode = 8'h07;
      ticks(1);
      expect_val("holdD_t1", S_BX, 332);
      drain();
      ticks(7);
      expect_val("holdD_t8", S_BX, 332);
      drain();
      ticks(1);
      expect_val("holdD_t9", S_BX, 356);
      drain();
      ticks(8);
      expect_val("holdD_t17", S_BX, 380);
      drain();
      keycode = 8'h00;

      // Hold A into the left wall
      do_reset();
      keycode = 8'h04;
      ticks(33);
      expect_val("holdA_wall_bx", S_BX, 212);
      expect_val("holdA_wall_by", S_BY, 36);
      drain();
      keycode = 8'h00;

      // Floor lock and respawn timing
      do_reset();
      ticks(599);
      expect_val("floor_row19_by", S_BY, 468);
      expect_val("floor_row19_lv", S_LV, 0);
      drain();
      expect_lock(4, 19);
      tick(0);
      expect_val("floor_lock_lv", S_LV, 1);
      expect_val("floor_hold_by", S_BY, 468);
      drain();
      @(posedge Clk); #1;
      expect_val("floor_spawn_lv", S_LV, 0);
      expect_val("floor_spawn_by", S_BY, 468);
      drain();
      @(posedge Clk); #1;
      expect_val("floor_respawn_by", S_BY, 12);
      expect_val("floor_respawn_bx", S_BX, 308);
      drain();
      expect_occ("occ_19_4", 19, 4, 1);
      expect_occ("occ_18_4", 18, 4, 0);
      expect_occ("occ_19_3", 19, 3, 0);

      // Lateral collision against the locked cell
      keycode = 8'h04;
      ticks(1);
      keycode = 8'h00;
      expect_val("lat_left_bx", S_BX, 284);
      drain();
      ticks(569);
      expect_val("lat_row19_by", S_BY, 468);
      drain();
      keycode = 8'h07;
      ticks(1);
      keycode = 8'h00;
      expect_val("lat_blocked_bx", S_BX, 284);
      drain();
      expect_lock(3, 19);
      ticks(29);
      expect_occ("occ_19_3_locked", 19, 3, 1);
      expect_occ("occ_oor_col", 19, 12, 0);

      // Game over after twenty locks in column 4
      do_reset();
      for (int k = 0; k < 20; k++) begin
         expect_lock(4, 19 - k);
         ticks((20 - k) * 30);
         expect_val($sformatf("go_after_lock%0d", k + 1), S_GO, (k == 19) ? 1 : 0);
         drain();
      end
      expect_occ("go_occ_0_4", 0, 4, 1);
      keycode = 8'h07;
      ticks(40);
      keycode = 8'h16;
      ticks(10);
      keycode = 8'h00;
      expect_val("go_frozen_bx", S_BX, 308);
      expect_val("go_frozen_by", S_BY, 12);
      expect_val("go_sticky", S_GO, 1);
      drain();
      do_reset();
      check_reset_state("go_reset");

      // Soft drop
      keycode = 8'h16;
      ticks(5);
      keycode = 8'h00;
`ifdef SOFT_DROP_EN
      expect_val("soft_drop_by", S_BY, 132);
`else
      expect_val("soft_drop_by", S_BY, 12);
`endif
      drain();

      repeat (4) @(posedge Clk);
      #1;
      chk("lock_count", n_lock_seen, n_lock_pushed);
      chk("lock_queue_left", lock_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
